// File: rtl/lod_norm_pipe.sv
// Leading-one detector + normaliser: reports 1-based position of the top set bit, leading-zero count, zero flag and left-normalised operand.
// Latency: 2 cycles from input transfer to io_out_valid; one operand per cycle while io_out_ready is high.
// Backpressure: valid/ready at both ports; a stalled output holds S2, S1 still fills once, then io_in_ready drops.
//
// Ports:
//    clock, reset        rising-edge clock, synchronous active-low reset
//    io_in_valid/ready   upstream handshake, io_in_bits is the operand
//    io_out_valid/ready  downstream handshake
//    io_out_pos          1-based index of the highest set bit (0 for a zero operand)
//    io_out_lzc          leading-zero count (WIDTH for a zero operand)
//    io_out_zero         operand was all zeros
//    io_out_norm         operand shifted left so its leading one sits at bit WIDTH-1

module lod_norm_pipe #(
   parameter int WIDTH = 10,
   parameter int POS_W = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             io_in_valid,
   output logic             io_in_ready,
   input  logic [WIDTH-1:0] io_in_bits,
   output logic             io_out_valid,
   input  logic             io_out_ready,
   output logic [POS_W-1:0] io_out_pos,
   output logic [POS_W-1:0] io_out_lzc,
   output logic             io_out_zero,
   output logic [WIDTH-1:0] io_out_norm
);

   // Stage 1 registers
   logic             s1Valid;
   logic [WIDTH-1:0] s1Data;
   logic [POS_W-1:0] s1Pos;
   logic [POS_W-1:0] s1Lzc;

   // Stage 2 registers (drive the outputs directly)
   logic             s2Valid;
   logic [POS_W-1:0] s2Pos;
   logic [POS_W-1:0] s2Lzc;
   logic             s2Zero;
   logic [WIDTH-1:0] s2Norm;

   logic             s1En;
   logic             s2En;
   logic [POS_W-1:0] inPos;
   logic [POS_W-1:0] inLzc;

   // A stage may load when it is empty or when the stage after it is moving.
   assign s2En        = !s2Valid || io_out_ready;
   assign s1En        = !s1Valid || s2En;
   assign io_in_ready = s1En;

   // Ascending scan: a later (higher) set bit overwrites earlier ones,
   // which gives the highest set bit priority.
   always_comb begin
      inPos = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (io_in_bits[i]) begin
            inPos = POS_W'(i + 1);
         end
      end
   end

   assign inLzc = POS_W'(WIDTH) - inPos;

   always_ff @(posedge clock) begin
      if (!reset) begin
         s1Valid <= 1'b0;
         s1Data  <= '0;
         s1Pos   <= '0;
         s1Lzc   <= '0;
         s2Valid <= 1'b0;
         s2Pos   <= '0;
         s2Lzc   <= '0;
         s2Zero  <= 1'b0;
         s2Norm  <= '0;
      end else begin
         if (s1En) begin
            s1Valid <= io_in_valid;
         end
         // Payload registers only move when real data arrives.
         if (s1En && io_in_valid) begin
            s1Data <= io_in_bits;
            s1Pos  <= inPos;
            s1Lzc  <= inLzc;
         end
         if (s2En) begin
            s2Valid <= s1Valid;
         end
         if (s2En && s1Valid) begin
            s2Pos  <= s1Pos;
            s2Lzc  <= s1Lzc;
            s2Zero <= (s1Pos == '0);
            // A zero operand has lzc == WIDTH, which shifts everything out.
            s2Norm <= s1Data << s1Lzc;
         end
      end
   end

   assign io_out_valid = s2Valid;
   assign io_out_pos   = s2Pos;
   assign io_out_lzc   = s2Lzc;
   assign io_out_zero  = s2Zero;
   assign io_out_norm  = s2Norm;

endmodule
